trap_seq: RTL

- Sequences trap entry and trap return for the core pipeline.
- Takes the prioritised synchronous exception from the trap priority unit and arbitrates it against pending interrupts.
- Selects the M or S handler via delegation, drains the pipeline, and issues one CSR update strobe and one PC redirect.
- Also sequences MRET/SRET privilege restore and redirect.

---
 rtl/trap_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/trap_seq.sv
// Trap entry / xRET sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
// Optional macro TRAP_VECTOR_EN enables vectored interrupt targets (tvec[1:0]==2'b01).
module trap_seq #(
    parameter int XLEN     = 64,
    parameter int ADDR_LEN = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                trap_en,
    input  logic [XLEN-1:0]     trap_cause,
    input  logic [ADDR_LEN-1:0] trap_epc,
    input  logic [XLEN-1:0]     trap_val,
    input  logic [XLEN-1:0]     irq_pend,
    input  logic [ADDR_LEN-1:0] irq_epc,
    input  logic                mret,
    input  logic                sret,
    input  logic [1:0]          prv_cur,
    input  logic                mstatus_mie,
    input  logic                mstatus_sie,
    input  logic [1:0]          mstatus_mpp,
    input  logic                mstatus_spp,
    input  logic [XLEN-1:0]     medeleg,
    input  logic [XLEN-1:0]     mideleg,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     stvec,
    input  logic [ADDR_LEN-1:0] mepc,
    input  logic [ADDR_LEN-1:0] sepc,
    input  logic                pipe_idle,
    output logic                busy,
    output logic                flush,
    output logic                csr_trap_m,
    output logic                csr_trap_s,
    output logic                csr_xret_m,
    output logic                csr_xret_s,
    output logic [XLEN-1:0]     csr_cause,
    output logic [ADDR_LEN-1:0] csr_epc,
    output logic [XLEN-1:0]     csr_val,
    output logic [1:0]          prv_nxt,
    output logic                prv_upd,
    output logic                redirect_valid,
    output logic [ADDR_LEN-1:0] redirect_pc
);
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_COMMIT, ST_REDIR} state_t;

    // Highest priority first: MEI, MSI, MTI, SEI, SSI, STI.
    localparam logic [3:0] IRQ_ORDER [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

    state_t              r_state;
    logic                r_busy, r_flush, r_prv_upd, r_redir_v;
    logic                r_trap_m, r_trap_s, r_xret_m, r_xret_s;
    logic                r_xret, r_to_s;
    logic [1:0]          r_prv_nxt;
    logic [XLEN-1:0]     r_cause, r_val;
    logic [ADDR_LEN-1:0] r_epc, r_tgt;

    logic                w_m_en, w_s_en, w_irq_hit, w_exc_s, w_irq_s, w_event;
    logic [3:0]          w_irq_code;
    logic [XLEN-1:0]     w_irq_cause, w_tvec, w_base, w_tgt;
    logic                w_unused;

    assign w_m_en = (prv_cur != 2'd3) || mstatus_mie;
    assign w_s_en = (prv_cur == 2'd0) || ((prv_cur == 2'd1) && mstatus_sie);

    always_comb begin
        w_irq_hit  = 1'b0;
        w_irq_code = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (!w_irq_hit && irq_pend[IRQ_ORDER[i]] &&
                (mideleg[IRQ_ORDER[i]] ? w_s_en : w_m_en)) begin
                w_irq_hit  = 1'b1;
                w_irq_code = IRQ_ORDER[i];
            end
        end
    end

    // A delegated interrupt is only selectable at S or below, so mideleg alone picks S.
    assign w_irq_cause = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
    assign w_exc_s     = (prv_cur <= 2'd1) && medeleg[trap_cause[5:0]];
    assign w_irq_s     = mideleg[w_irq_code];
    assign w_tvec      = (trap_en ? w_exc_s : w_irq_s) ? stvec : mtvec;
    assign w_base      = {w_tvec[XLEN-1:2], 2'b00};
    assign w_event     = trap_en || w_irq_hit || mret || sret;
`ifdef TRAP_VECTOR_EN
    assign w_tgt = (!trap_en && (w_tvec[1:0] == 2'b01))
                 ? w_base + {{(XLEN-6){1'b0}}, w_irq_code, 2'b00} : w_base;
`else
    assign w_tgt = w_base;
`endif
    assign w_unused = ^{trap_cause, irq_pend, medeleg, mideleg, w_tvec};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_flush   <= 1'b0;
            r_trap_m  <= 1'b0;
            r_trap_s  <= 1'b0;
            r_xret_m  <= 1'b0;
            r_xret_s  <= 1'b0;
            r_prv_upd <= 1'b0;
            r_redir_v <= 1'b0;
            r_xret    <= 1'b0;
            r_to_s    <= 1'b0;
            r_prv_nxt <= 2'd0;
            r_cause   <= '0;
            r_val     <= '0;
            r_epc     <= '0;
            r_tgt     <= '0;
        end else begin
            r_trap_m  <= 1'b0;
            r_trap_s  <= 1'b0;
            r_xret_m  <= 1'b0;
            r_xret_s  <= 1'b0;
            r_prv_upd <= 1'b0;
            r_redir_v <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trap_en || w_irq_hit) begin
                        r_xret  <= 1'b0;
                        r_to_s  <= trap_en ? w_exc_s : w_irq_s;
                        r_cause <= trap_en ? trap_cause : w_irq_cause;
                        r_epc   <= trap_en ? trap_epc : irq_epc;
                        r_val   <= trap_en ? trap_val : '0;
                        r_tgt   <= ADDR_LEN'(w_tgt);
                    end else if (mret || sret) begin
                        r_xret  <= 1'b1;
                        r_to_s  <= !mret;
                    end
                    if (w_event) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                        r_flush <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_idle) begin
                        r_state   <= ST_COMMIT;
                        r_trap_m  <= !r_xret && !r_to_s;
                        r_trap_s  <= !r_xret &&  r_to_s;
                        r_xret_m  <=  r_xret && !r_to_s;
                        r_xret_s  <=  r_xret &&  r_to_s;
                        r_prv_upd <= 1'b1;
                        r_prv_nxt <= !r_xret ? (r_to_s ? 2'd1 : 2'd3)
                                             : (r_to_s ? {1'b0, mstatus_spp} : mstatus_mpp);
                    end
                end
                ST_COMMIT: begin
                    r_state   <= ST_REDIR;
                    r_flush   <= 1'b0;
                    r_redir_v <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign flush          = r_flush;
    assign csr_trap_m     = r_trap_m;
    assign csr_trap_s     = r_trap_s;
    assign csr_xret_m     = r_xret_m;
    assign csr_xret_s     = r_xret_s;
    assign csr_cause      = r_cause;
    assign csr_epc        = r_epc;
    assign csr_val        = r_val;
    assign prv_nxt        = r_prv_nxt;
    assign prv_upd        = r_prv_upd;
    assign redirect_valid = r_redir_v;
    // xRET targets come from the live xepc so the COMMIT-cycle CSR view is used.
    assign redirect_pc    = !r_redir_v ? '0 : (!r_xret ? r_tgt : (r_to_s ? sepc : mepc));
endmodule
